// File: rtl/sixteen_to_four_enc.sv
// Request accumulator and encoder: collects request bits, then presents one
// granted index at a time with valid/ack handshaking, in fixed or round-robin order.
module sixteen_to_four_enc (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req_in,
  input  logic        req_valid,
  input  logic        rr_mode,
  input  logic        out_ack,
  output logic [3:0]  out_code,
  output logic        out_valid,
  output logic [15:0] pending,
  output logic [4:0]  pending_cnt,
  output logic        multi_err
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic        acked;
  logic        select_now;
  logic [3:0]  base_ptr;
  logic [3:0]  sel_code;
  logic [15:0] clear_mask;
  logic [15:0] capture;
  logic        multi_hot;

  // An ack moves the round-robin pointer, and the grant made on that same
  // edge already searches from the moved pointer.
  always_comb begin
    acked      = (state == PRESENT) && out_ack;
    select_now = ((state == IDLE) || acked) && (pending != 16'h0000);
    base_ptr   = acked ? out_code + 4'd1 : ptr;
    capture    = req_valid ? req_in : 16'h0000;
    multi_hot  = (req_in & (req_in - 16'h0001)) != 16'h0000;
  end

  always_comb begin
    logic       found;
    logic [3:0] idx;
    sel_code = 4'd0;
    found    = 1'b0;
    idx      = 4'd0;
    if (rr_mode) begin
      for (int k = 0; k < 16; k++) begin
        idx = base_ptr + 4'(k);
        if (!found && pending[idx]) begin
          sel_code = idx;
          found    = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pending[i]) sel_code = 4'(i);
      end
    end
    clear_mask = select_now ? (16'h0001 << sel_code) : 16'h0000;
  end

  always_comb begin
    pending_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pending_cnt = pending_cnt + {4'd0, pending[i]};
    end
  end

  // Capture is ORed in after the grant clear, so a bit re-requested on the
  // edge it is granted stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 16'h0000;
      out_code  <= 4'd0;
      out_valid <= 1'b0;
      multi_err <= 1'b0;
      ptr       <= 4'd0;
    end else begin
      pending <= (pending & ~clear_mask) | capture;
      if (req_valid && multi_hot) multi_err <= 1'b1;
      if (acked) ptr <= out_code + 4'd1;
      case (state)
        IDLE: begin
          if (select_now) begin
            state     <= PRESENT;
            out_code  <= sel_code;
            out_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (out_ack) begin
            if (select_now) begin
              out_code <= sel_code;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sixteen_to_four_enc.sv
// Bench for sixteen_to_four_enc: directed scenarios with literal expectations,
// then random traffic compared each cycle against a behavioural model.
module tb_sixteen_to_four_enc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req_in = '0;
  logic        req_valid = 1'b0;
  logic        rr_mode = 1'b0;
  logic        out_ack = 1'b0;
  logic [3:0]  out_code;
  logic        out_valid;
  logic [15:0] pending;
  logic [4:0]  pending_cnt;
  logic        multi_err;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] m_pend;
  int          m_code;
  bit          m_valid;
  int          m_ptr;
  bit          m_err;

  sixteen_to_four_enc dut (
    .clk(clk), .reset(reset), .req_in(req_in), .req_valid(req_valid),
    .rr_mode(rr_mode), .out_ack(out_ack), .out_code(out_code),
    .out_valid(out_valid), .pending(pending), .pending_cnt(pending_cnt),
    .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  function automatic int ones(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  // Fixed: highest set index. Round-robin: first set index at or after ptr.
  function automatic int pick(input logic [15:0] p, input bit rr, input int ptr);
    if (!rr) begin
      for (int i = 15; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int k = 0; k < 16; k++) if (p[(ptr + k) % 16]) return (ptr + k) % 16;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = '0; m_code = 0; m_valid = 0; m_ptr = 0; m_err = 0;
    end else begin
      bit acked;
      bit grant;
      int c;
      acked = m_valid && out_ack;
      if (acked) m_ptr = (m_code + 1) % 16;
      grant = (!m_valid || acked) && (m_pend != 0);
      if (grant) begin
        c = pick(m_pend, rr_mode, m_ptr);
        m_pend[c] = 1'b0;
        m_code = c;
        m_valid = 1;
      end else if (acked) begin
        m_valid = 0;
      end
      if (req_valid) begin
        m_pend = m_pend | req_in;
        if (ones(req_in) > 1) m_err = 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("model_valid", 32'(out_valid), 32'(m_valid));
    check_output("model_pending", 32'(pending), 32'(m_pend));
    check_output("model_cnt", 32'(pending_cnt), 32'(ones(m_pend)));
    check_output("model_err", 32'(multi_err), 32'(m_err));
    if (m_valid) check_output("model_code", 32'(out_code), 32'(m_code));
  end

  task automatic apply_stimulus(input logic [15:0] r, input logic rv, input logic rr, input logic ack);
    req_in = r; req_valid = rv; rr_mode = rr; out_ack = ack;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b0;
    check_output("reset_valid", 32'(out_valid), 32'd0);
    check_output("reset_pending", 32'(pending), 32'd0);

    // single request, fixed priority
    apply_stimulus(16'h0001, 1, 0, 0);
    check_output("s1_pend", 32'(pending), 32'h0001);
    check_output("s1_wait", 32'(out_valid), 32'd0);
    apply_stimulus(16'h0000, 0, 0, 0);
    check_output("s1_valid", 32'(out_valid), 32'd1);
    check_output("s1_code", 32'(out_code), 32'd0);
    apply_stimulus(16'h0000, 0, 0, 1);
    check_output("s1_ack_valid", 32'(out_valid), 32'd0);
    check_output("s1_ack_pend", 32'(pending), 32'd0);

    // 8421 drained highest first
    apply_stimulus(16'h8421, 1, 0, 0);
    check_output("s2_err", 32'(multi_err), 32'd1);
    apply_stimulus(16'h0000, 0, 0, 0);
    check_output("s2_code_f", 32'(out_code), 32'hF);
    check_output("s2_cnt3", 32'(pending_cnt), 32'd3);
    apply_stimulus(16'h0000, 0, 0, 1);
    check_output("s2_code_a", 32'(out_code), 32'hA);
    check_output("s2_cnt2", 32'(pending_cnt), 32'd2);
    apply_stimulus(16'h0000, 0, 0, 1);
    check_output("s2_code_5", 32'(out_code), 32'h5);
    check_output("s2_cnt1", 32'(pending_cnt), 32'd1);
    apply_stimulus(16'h0000, 0, 0, 1);
    check_output("s2_code_0", 32'(out_code), 32'h0);
    check_output("s2_cnt0", 32'(pending_cnt), 32'd0);
    apply_stimulus(16'h0000, 0, 0, 1);
    check_output("s2_idle", 32'(out_valid), 32'd0);

    // round-robin wrap
    do_reset();
    apply_stimulus(16'h8002, 1, 1, 0);
    apply_stimulus(16'h0000, 0, 1, 0);
    check_output("s3_code_1", 32'(out_code), 32'h1);
    apply_stimulus(16'h0000, 0, 1, 1);
    check_output("s3_code_f", 32'(out_code), 32'hF);
    apply_stimulus(16'h0001, 1, 1, 0);
    check_output("s3_hold_f", 32'(out_code), 32'hF);
    apply_stimulus(16'h0000, 0, 1, 1);
    check_output("s3_code_0", 32'(out_code), 32'h0);
    apply_stimulus(16'h0000, 0, 1, 1);
    check_output("s3_idle", 32'(out_valid), 32'd0);
    apply_stimulus(16'h0007, 1, 1, 0);
    apply_stimulus(16'h0000, 0, 1, 0);
    check_output("s3_ptr1_code", 32'(out_code), 32'h1);
    apply_stimulus(16'h0000, 0, 1, 1);
    check_output("s3_next_2", 32'(out_code), 32'h2);
    apply_stimulus(16'h0000, 0, 1, 1);
    check_output("s3_wrap_0", 32'(out_code), 32'h0);
    apply_stimulus(16'h0000, 0, 1, 1);

    // hold without ack while captures accumulate
    do_reset();
    apply_stimulus(16'h0010, 1, 0, 0);
    apply_stimulus(16'h0000, 0, 0, 0);
    check_output("s4_code", 32'(out_code), 32'h4);
    apply_stimulus(16'h0001, 1, 0, 0);
    check_output("s4_cnt_a", 32'(pending_cnt), 32'd1);
    apply_stimulus(16'h0002, 1, 0, 0);
    check_output("s4_cnt_b", 32'(pending_cnt), 32'd2);
    apply_stimulus(16'h0100, 1, 0, 0);
    apply_stimulus(16'h0002, 1, 0, 0);
    check_output("s4_merge", 32'(pending_cnt), 32'd3);
    apply_stimulus(16'h0000, 1, 0, 0);
    check_output("s4_zero_cap", 32'(pending), 32'h0103);
    check_output("s4_stable", 32'(out_code), 32'h4);
    apply_stimulus(16'h0000, 0, 0, 1);
    check_output("s4_next_8", 32'(out_code), 32'h8);

    // capture wins over clear on the same bit
    do_reset();
    apply_stimulus(16'h0008, 1, 0, 0);
    apply_stimulus(16'h0008, 1, 0, 0);
    check_output("s5_code", 32'(out_code), 32'h3);
    check_output("s5_pend", 32'(pending), 32'h0008);
    apply_stimulus(16'h0000, 0, 0, 1);
    check_output("s5_regrant", 32'(out_code), 32'h3);
    check_output("s5_valid", 32'(out_valid), 32'd1);
    apply_stimulus(16'h0000, 0, 0, 1);

    // async reset mid-present
    apply_stimulus(16'h01F0, 1, 0, 0);
    apply_stimulus(16'h0000, 0, 0, 0);
    check_output("s6_pend", 32'(pending), 32'h00F0);
    #2 reset = 1'b1;
    #1;
    check_output("s6_async_valid", 32'(out_valid), 32'd0);
    check_output("s6_async_pend", 32'(pending), 32'd0);
    check_output("s6_async_code", 32'(out_code), 32'd0);
    check_output("s6_async_cnt", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(16'h0000, 0, 0, 0);
    apply_stimulus(16'h0000, 0, 0, 0);
    check_output("s6_no_stale", 32'(out_valid), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] r;
      case ($urandom_range(0, 2))
        0: r = 16'h0000;
        1: r = 16'h0001 << $urandom_range(0, 15);
        default: r = 16'($urandom & $urandom);
      endcase
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      apply_stimulus(r, $urandom_range(0, 9) < 4, (n / 200) % 2 == 1 ? 1'b1 : 1'($urandom_range(0, 7) == 0),
                     $urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
